// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo I2S serializer for the codec DAC path.
// SoC frames {left,right} are buffered in a small FIFO and shifted out
// MSB-first on audio_DACDAT, framed by the codec-mastered BCLK/DACLRCK.
// Both codec clocks are synchronized into clk_fpga; all serializer
// activity happens on detected BCLK falling edges.
// Optional feature macro: AUDIO_TX_UNDERRUN_CNT_EN (saturating underrun counter).
module audio_i2s_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_fpga,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  input  logic                          audio_BCLK,
  input  logic                          audio_DACLRCK,
  output logic                          audio_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Codec clock synchronizers
  logic bclk_meta_q, bclk_sync_q, bclk_hist_q;
  logic lrck_meta_q, lrck_sync_q;
  logic lrck_prev_q;

  // FIFO storage and bookkeeping
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;

  // Serializer state
  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   frame_r_q;
  logic [CNT_W-1:0]    bits_q;
  logic                dacdat_q;

  logic                bclk_fall, lrck_fall_edge, lrck_rise_edge;
  logic                full, empty, push, pop_req, pop_ok;
  logic [2*DATA_W-1:0] pop_data;
  logic [DATA_W-1:0]   load_l, load_r;

  // Two-stage synchronizers plus BCLK history for edge detection
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      bclk_meta_q <= 1'b0;
      bclk_sync_q <= 1'b0;
      bclk_hist_q <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
    end else begin
      bclk_meta_q <= audio_BCLK;
      bclk_sync_q <= bclk_meta_q;
      bclk_hist_q <= bclk_sync_q;
      lrck_meta_q <= audio_DACLRCK;
      lrck_sync_q <= lrck_meta_q;
    end
  end

  assign bclk_fall      = !bclk_sync_q && bclk_hist_q;
  assign lrck_fall_edge = bclk_fall && lrck_prev_q && !lrck_sync_q;
  assign lrck_rise_edge = bclk_fall && !lrck_prev_q && lrck_sync_q;

  // A left-slot start always requests a frame; the one that locks IDLE does too.
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign s_ready  = !full;
  assign push     = s_valid && !full;
  assign pop_req  = lrck_fall_edge;
  assign pop_ok   = pop_req && !empty;
  assign underrun = pop_req && empty;

  assign pop_data = mem_q[rd_ptr_q];
  assign load_l   = pop_ok ? pop_data[2*DATA_W-1:DATA_W] : '0;
  assign load_r   = pop_ok ? pop_data[DATA_W-1:0]        : '0;

  // Next FIFO level; simultaneous push and pop cancel out
  always_comb begin
    level_d = level_q;
    case ({push, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and level
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Frame storage, no reset so it maps onto RAM
  always_ff @(posedge clk_fpga) begin
    if (push) mem_q[wr_ptr_q] <= {s_left, s_right};
  end

  // Serializer FSM: slot tracking, word load, MSB-first shift with 1-bit delay
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lrck_prev_q <= 1'b0;
      shreg_q     <= '0;
      frame_r_q   <= '0;
      bits_q      <= '0;
      dacdat_q    <= 1'b0;
    end else if (bclk_fall) begin
      lrck_prev_q <= lrck_sync_q;
      if (lrck_fall_edge) begin
        // Left slot starts (and locks IDLE); this edge is the I2S delay bit
        state_q   <= ST_RUN;
        frame_r_q <= load_r;
        shreg_q   <= load_l;
        bits_q    <= CNT_W'(DATA_W);
        dacdat_q  <= 1'b0;
      end else if (lrck_rise_edge) begin
        dacdat_q <= 1'b0;
        if (state_q == ST_RUN) begin
          shreg_q <= frame_r_q;
          bits_q  <= CNT_W'(DATA_W);
        end
      end else if (bits_q != '0) begin
        dacdat_q <= shreg_q[DATA_W-1];
        shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
        bits_q   <= bits_q - CNT_W'(1);
      end else begin
        // Slot padding after the word has been sent
        dacdat_q <= 1'b0;
      end
    end
  end

  assign audio_DACDAT = dacdat_q;
  assign fifo_level   = level_q;

`ifdef AUDIO_TX_UNDERRUN_CNT_EN
  logic [15:0] und_cnt_q;

  // Saturating count of failed pops
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      und_cnt_q <= '0;
    end else if (underrun && (und_cnt_q != 16'hFFFF)) begin
      und_cnt_q <= und_cnt_q + 16'd1;
    end
  end

  assign underrun_count = und_cnt_q;
`else
  assign underrun_count = '0;
`endif

endmodule
